// File: rtl/bsg_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : bsg_skid_buf
// Purpose  : Two-entry valid/ready skid buffer, WIDTH_P bits wide. It sits
//            directly upstream of the bsg_buf wire buffer and feeds its i input
//            from data_o. The ready_o handshake comes from a flop, so there is
//            no combinational path from yumi_i to ready_o. The buffer sustains
//            one word per cycle.
// Ports    : clk_i       in   1        single clock, all state on posedge
//            reset_i     in   1        asynchronous active-high reset
//            v_i         in   1        upstream word valid
//            data_i      in   WIDTH_P  upstream payload
//            ready_o     out  1        buffer accepts a word this cycle
//            v_o         out  1        data_o holds a valid word
//            data_o      out  WIDTH_P  head word (drives bsg_buf.i)
//            yumi_i      in   1        downstream consumes head this cycle
//            stall_cnt_o out  16       saturating count of cycles with
//                                      v_i=1 and ready_o=0 (only present
//                                      when BSG_SKID_BUF_STALL_CNT_EN is
//                                      defined)
// Options  : `define BSG_SKID_BUF_STALL_CNT_EN adds the stall counter
// Revision : 1.0  initial release
// ============================================================================
module bsg_skid_buf #(
    parameter int WIDTH_P = 64
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [WIDTH_P-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [WIDTH_P-1:0] data_o,
    input  logic               yumi_i
`ifdef BSG_SKID_BUF_STALL_CNT_EN
    ,
    output logic [15:0]        stall_cnt_o
`endif
);

    localparam logic [1:0] c_EMPTY = 2'd0;
    localparam logic [1:0] c_ONE   = 2'd1;
    localparam logic [1:0] c_TWO   = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_ready;
    logic [WIDTH_P-1:0] r_head;
    logic [WIDTH_P-1:0] r_tail;

    logic               w_enq;
    logic               w_deq;
    logic               w_head_ld;
    logic               w_head_from_tail;
    logic               w_tail_ld;

    // A yumi_i with nothing held is ignored, so it can never corrupt state.
    assign w_enq = v_i & r_ready;
    assign w_deq = yumi_i & (r_state != c_EMPTY);

    always_comb begin
        w_state_nxt      = r_state;
        w_head_ld        = 1'b0;
        w_head_from_tail = 1'b0;
        w_tail_ld        = 1'b0;
        case (r_state)
            c_EMPTY: begin
                if (w_enq) begin
                    w_state_nxt = c_ONE;
                    w_head_ld   = 1'b1;
                end
            end
            c_ONE: begin
                if (w_enq && w_deq) begin
                    // Head leaves and the new word replaces it in one cycle.
                    w_head_ld = 1'b1;
                end else if (w_enq) begin
                    w_state_nxt = c_TWO;
                    w_tail_ld   = 1'b1;
                end else if (w_deq) begin
                    w_state_nxt = c_EMPTY;
                end
            end
            c_TWO: begin
                // ready_o is low here, so only a dequeue is possible.
                if (w_deq) begin
                    w_state_nxt      = c_ONE;
                    w_head_ld        = 1'b1;
                    w_head_from_tail = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_EMPTY;
            end
        endcase
    end

    // ready_o is registered from the next state. It stays low through reset
    // and rises on the first edge after reset is released.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= c_EMPTY;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt != c_TWO);
        end
    end

    // Payload registers need no reset; their contents are ignored while
    // v_o is low.
    always_ff @(posedge clk_i) begin
        if (w_head_ld) begin
            r_head <= w_head_from_tail ? r_tail : data_i;
        end
        if (w_tail_ld) begin
            r_tail <= data_i;
        end
    end

    assign ready_o = r_ready;
    assign v_o     = (r_state != c_EMPTY);
    assign data_o  = r_head;

`ifdef BSG_SKID_BUF_STALL_CNT_EN
    logic [15:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall = v_i & ~r_ready;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_stall_cnt <= 16'd0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bsg_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_skid_buf
// Purpose  : Directed self-checking bench for bsg_skid_buf: streaming,
//            backpressure, simultaneous enq/deq, asynchronous mid-operation
//            reset, an illegal yumi_i, and the optional stall counter.
// Revision : 1.0  initial release
// ============================================================================
module tb_bsg_skid_buf;

    localparam int WIDTH_P = 64;

    logic               clk_i;
    logic               reset_i;
    logic               v_i;
    logic [WIDTH_P-1:0] data_i;
    logic               ready_o;
    logic               v_o;
    logic [WIDTH_P-1:0] data_o;
    logic               yumi_i;
`ifdef BSG_SKID_BUF_STALL_CNT_EN
    logic [15:0]        stall_cnt_o;
`endif

    int n_checks;
    int n_errors;
    int n_illegal;

    bsg_skid_buf #(.WIDTH_P(WIDTH_P)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (v_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .v_o     (v_o),
        .data_o  (data_o),
        .yumi_i  (yumi_i)
`ifdef BSG_SKID_BUF_STALL_CNT_EN
        ,
        .stall_cnt_o (stall_cnt_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Protocol monitor: yumi_i with no valid word is illegal.
    initial n_illegal = 0;
    always @(posedge clk_i) begin
        if (!reset_i && yumi_i) begin
            assert (v_o) else n_illegal = n_illegal + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply inputs for one cycle, then sample 1 time unit after the edge.
    task automatic step(input logic v, input logic [63:0] d, input logic y);
        v_i    = v;
        data_i = d;
        yumi_i = y;
        @(posedge clk_i);
        #1;
    endtask

    localparam logic [63:0] c_A = 64'hA5A5_A5A5_A5A5_A5A5;
    localparam logic [63:0] c_B = 64'h5A5A_5A5A_5A5A_5A5A;
    localparam logic [63:0] c_C = 64'hC3C3_C3C3_C3C3_C3C3;

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_i  = 1'b1;
        v_i      = 1'b0;
        data_i   = '0;
        yumi_i   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_v", {63'd0, v_o}, 64'd0);
        check("rst_ready", {63'd0, ready_o}, 64'd0);
        reset_i = 1'b0;
        #1;
        check("rel_ready_pre_edge", {63'd0, ready_o}, 64'd0);
        step(1'b0, 64'd0, 1'b0);
        check("rel_ready", {63'd0, ready_o}, 64'd1);
        check("rel_v", {63'd0, v_o}, 64'd0);

        // 1. Streaming at full rate
        step(1'b1, 64'd1, 1'b0);
        check("s1_data", data_o, 64'd1);
        check("s1_v", {63'd0, v_o}, 64'd1);
        check("s1_ready", {63'd0, ready_o}, 64'd1);
        for (int k = 2; k <= 4; k++) begin
            step(1'b1, 64'(k), 1'b1);
            check("s_stream_data", data_o, 64'(k));
            check("s_stream_ready", {63'd0, ready_o}, 64'd1);
        end
        step(1'b0, 64'd0, 1'b1);
        check("s_drain_v", {63'd0, v_o}, 64'd0);

        // 2. Backpressure
        step(1'b1, c_A, 1'b0);
        check("bp_one_data", data_o, c_A);
        check("bp_one_ready", {63'd0, ready_o}, 64'd1);
        step(1'b1, c_B, 1'b0);
        check("bp_two_ready", {63'd0, ready_o}, 64'd0);
        check("bp_two_data", data_o, c_A);
        step(1'b1, c_C, 1'b0);
        step(1'b1, c_C, 1'b0);
        check("bp_hold_ready", {63'd0, ready_o}, 64'd0);
        check("bp_hold_data", data_o, c_A);
        step(1'b1, c_C, 1'b1);
        check("bp_rel1_data", data_o, c_B);
        check("bp_rel1_ready", {63'd0, ready_o}, 64'd1);
        step(1'b1, c_C, 1'b1);
        check("bp_rel2_data", data_o, c_C);
        check("bp_rel2_v", {63'd0, v_o}, 64'd1);
        step(1'b0, 64'd0, 1'b1);
        check("bp_drain_v", {63'd0, v_o}, 64'd0);

        // 3. Simultaneous enq/deq while holding one word
        step(1'b1, 64'h11, 1'b0);
        check("sim_head", data_o, 64'h11);
        step(1'b1, 64'h22, 1'b1);
        check("sim_data", data_o, 64'h22);
        check("sim_v", {63'd0, v_o}, 64'd1);
        check("sim_ready", {63'd0, ready_o}, 64'd1);
        step(1'b0, 64'd0, 1'b1);
        check("sim_drain_v", {63'd0, v_o}, 64'd0);

        // 4. Asynchronous reset while full
        step(1'b1, 64'h33, 1'b0);
        step(1'b1, 64'h44, 1'b0);
        check("ar_full_ready", {63'd0, ready_o}, 64'd0);
        check("ar_full_v", {63'd0, v_o}, 64'd1);
        v_i = 1'b0;
        #2;
        reset_i = 1'b1;
        #1;
        check("ar_async_v", {63'd0, v_o}, 64'd0);
        check("ar_async_ready", {63'd0, ready_o}, 64'd0);
        @(posedge clk_i);
        #3;
        reset_i = 1'b0;
        #1;
        check("ar_rel_ready_pre_edge", {63'd0, ready_o}, 64'd0);
        step(1'b0, 64'd0, 1'b0);
        check("ar_rel_ready", {63'd0, ready_o}, 64'd1);
        step(1'b1, 64'h55, 1'b0);
        check("ar_first_data", data_o, 64'h55);
        check("ar_first_v", {63'd0, v_o}, 64'd1);
        step(1'b0, 64'd0, 1'b1);
        check("ar_drain_v", {63'd0, v_o}, 64'd0);

        // 5. Illegal yumi_i while empty
        check("ill_none_yet", 64'(n_illegal), 64'd0);
        step(1'b0, 64'd0, 1'b1);
        check("ill_flagged", 64'(n_illegal), 64'd1);
        check("ill_v", {63'd0, v_o}, 64'd0);
        check("ill_ready", {63'd0, ready_o}, 64'd1);
        step(1'b0, 64'd0, 1'b0);
        check("ill_still_empty", {63'd0, v_o}, 64'd0);

`ifdef BSG_SKID_BUF_STALL_CNT_EN
        // 6. Stall counter
        #2;
        reset_i = 1'b1;
        @(posedge clk_i);
        #3;
        reset_i = 1'b0;
        step(1'b0, 64'd0, 1'b0);
        check("sc_clear", {48'd0, stall_cnt_o}, 64'd0);
        step(1'b1, 64'h66, 1'b0);
        step(1'b1, 64'h77, 1'b0);
        check("sc_full_zero", {48'd0, stall_cnt_o}, 64'd0);
        repeat (10) step(1'b1, 64'h88, 1'b0);
        check("sc_ten", {48'd0, stall_cnt_o}, 64'd10);
        repeat (70000) step(1'b1, 64'h88, 1'b0);
        check("sc_sat", {48'd0, stall_cnt_o}, 64'hFFFF);
        v_i = 1'b0;
        #2;
        reset_i = 1'b1;
        #1;
        check("sc_async_clear", {48'd0, stall_cnt_o}, 64'd0);
        @(posedge clk_i);
        #3;
        reset_i = 1'b0;
        step(1'b0, 64'd0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
